// File: rtl/candidate_selector_if.sv
// Handshake bundle between the control block / accumulator and the candidate selector.
// The slave side is the selector; the master side drives candidates and control.
interface candidate_selector_if #(
    parameter int unsigned CAND_W = 8,
    parameter int unsigned IDX_W  = 4
);
    logic              start;
    logic [CAND_W-1:0] candidate;
    logic              cand_valid;
    logic              ack;
    logic [CAND_W-1:0] best_value;
    logic [IDX_W-1:0]  best_index;
    logic              tie;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, candidate, cand_valid, ack,
        input  best_value, best_index, tie, busy, done, err
    );

    modport slave (
        input  start, candidate, cand_valid, ack,
        output best_value, best_index, tie, busy, done, err
    );
endinterface

// File: rtl/candidate_selector.sv
// Running-maximum selector over a fixed-length search of NUM_CAND candidates.
// Holds the winning score, its index and a tie flag until acknowledged.
module candidate_selector #(
    parameter int unsigned CAND_W   = 8,
    parameter int unsigned NUM_CAND = 16,
    parameter int unsigned IDX_W    = 4
) (
    input logic                 clk,
    input logic                 rst,
    candidate_selector_if.slave bus
);
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CAND - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CAND_W-1:0] best_value_q, best_value_d;
    logic [IDX_W-1:0]  best_index_q, best_index_d;
    logic              tie_q, tie_d;
    logic              err_q, err_d;
    logic              clear;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_value_d = best_value_q;
        best_index_d = best_index_q;
        tie_d        = tie_q;
        err_d        = err_q;
        clear        = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StCollect;
                    clear   = 1'b1;
                end else if (bus.cand_valid) begin
                    err_d = 1'b1;
                end
            end
            StCollect: begin
                // A restart discards any coincident candidate.
                if (bus.start) begin
                    clear = 1'b1;
                end else if (bus.cand_valid) begin
                    if (idx_q == '0 || bus.candidate > best_value_q) begin
                        best_value_d = bus.candidate;
                        best_index_d = idx_q;
                        tie_d        = 1'b0;
                    end else if (bus.candidate == best_value_q) begin
                        tie_d = 1'b1;
                    end
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            StDone: begin
                if (bus.cand_valid) begin
                    err_d = 1'b1;
                end
                if (bus.ack) begin
                    if (bus.start) begin
                        state_d = StCollect;
                        clear   = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            idx_d        = '0;
            best_value_d = '0;
            best_index_d = '0;
            tie_d        = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            best_value_q <= '0;
            best_index_q <= '0;
            tie_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_value_q <= best_value_d;
            best_index_q <= best_index_d;
            tie_q        <= tie_d;
            err_q        <= err_d;
        end
    end

    assign bus.best_value = best_value_q;
    assign bus.best_index = best_index_q;
    assign bus.tie        = tie_q;
    assign bus.err        = err_q;
    assign bus.busy       = (state_q == StCollect);
    assign bus.done       = (state_q == StDone);
endmodule

// File: tb/tb_candidate_selector.sv
// Bench for candidate_selector: a vector table plus hand-written search sequences,
// with expected outputs queued at drive time and popped after each clock edge.
module tb_candidate_selector;
    typedef struct packed {
        logic [7:0] bv;
        logic [3:0] bi;
        logic       tie;
        logic       busy;
        logic       done;
        logic       err;
    } out_t;

    typedef struct packed {
        logic       r;
        logic       st;
        logic       cv;
        logic [7:0] c;
        logic       ak;
        out_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    out_t sb_q[$];

    candidate_selector_if #(.CAND_W(8), .IDX_W(4)) bus ();

    candidate_selector #(.CAND_W(8), .NUM_CAND(16), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic out_t o(input logic [7:0] bv, input logic [3:0] bi, input logic tie,
                               input logic busy, input logic done, input logic err);
        o = '{bv: bv, bi: bi, tie: tie, busy: busy, done: done, err: err};
    endfunction

    // Drive one cycle of inputs, optionally queue the expected post-edge outputs and check them.
    task automatic cyc(input logic r, input logic st, input logic cv, input logic [7:0] c,
                       input logic ak, input logic chk, input out_t e, input string nm);
        out_t got, exp_o;
        rst            = r;
        bus.start      = st;
        bus.cand_valid = cv;
        bus.candidate  = c;
        bus.ack        = ak;
        if (chk) sb_q.push_back(e);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.cand_valid = 1'b0;
        bus.candidate  = 8'd0;
        bus.ack        = 1'b0;
        if (chk) begin
            exp_o = sb_q.pop_front();
            got   = o(bus.best_value, bus.best_index, bus.tie, bus.busy, bus.done, bus.err);
            total++;
            if (got !== exp_o) begin
                bad++;
                $display("FAIL %s: got bv=%0d bi=%0d tie=%0b busy=%0b done=%0b err=%0b, want bv=%0d bi=%0d tie=%0b busy=%0b done=%0b err=%0b",
                         nm, got.bv, got.bi, got.tie, got.busy, got.done, got.err,
                         exp_o.bv, exp_o.bi, exp_o.tie, exp_o.busy, exp_o.done, exp_o.err);
            end
        end
    endtask

    // Feed 16 back-to-back candidates; expectations follow the running-max rules.
    task automatic feed(input logic [7:0] v[16], input string nm);
        logic [7:0] bv = 8'd0;
        logic [3:0] bi = 4'd0;
        logic       tie = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || v[i] > bv) begin
                bv  = v[i];
                bi  = 4'(i);
                tie = 1'b0;
            end else if (v[i] == bv) begin
                tie = 1'b1;
            end
            cyc(0, 0, 1, v[i], 0, 1, o(bv, bi, tie, i != 15, i == 15, 1'b0), nm);
        end
    endtask

    vec_t       tbl[14];
    logic [7:0] va[16];
    logic [7:0] vz[16];
    logic [7:0] vc[16];

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.cand_valid = 1'b0;
        bus.candidate  = 8'd0;
        bus.ack        = 1'b0;

        tbl[0]  = '{r: 1, st: 0, cv: 0, c: 8'd0,   ak: 0, e: o(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{r: 0, st: 0, cv: 1, c: 8'd5,   ak: 0, e: o(0, 0, 0, 0, 0, 1)};
        tbl[2]  = '{r: 0, st: 0, cv: 0, c: 8'd0,   ak: 0, e: o(0, 0, 0, 0, 0, 1)};
        tbl[3]  = '{r: 0, st: 1, cv: 0, c: 8'd0,   ak: 0, e: o(0, 0, 0, 1, 0, 0)};
        tbl[4]  = '{r: 0, st: 0, cv: 1, c: 8'd5,   ak: 0, e: o(5, 0, 0, 1, 0, 0)};
        tbl[5]  = '{r: 0, st: 0, cv: 1, c: 8'd5,   ak: 0, e: o(5, 0, 1, 1, 0, 0)};
        tbl[6]  = '{r: 0, st: 0, cv: 1, c: 8'd8,   ak: 0, e: o(8, 2, 0, 1, 0, 0)};
        tbl[7]  = '{r: 0, st: 0, cv: 1, c: 8'd3,   ak: 0, e: o(8, 2, 0, 1, 0, 0)};
        tbl[8]  = '{r: 0, st: 0, cv: 1, c: 8'd8,   ak: 0, e: o(8, 2, 1, 1, 0, 0)};
        tbl[9]  = '{r: 0, st: 1, cv: 1, c: 8'd200, ak: 0, e: o(0, 0, 0, 1, 0, 0)};
        tbl[10] = '{r: 0, st: 0, cv: 1, c: 8'd4,   ak: 0, e: o(4, 0, 0, 1, 0, 0)};
        tbl[11] = '{r: 0, st: 0, cv: 1, c: 8'd6,   ak: 0, e: o(6, 1, 0, 1, 0, 0)};
        tbl[12] = '{r: 1, st: 0, cv: 1, c: 8'd9,   ak: 0, e: o(0, 0, 0, 0, 0, 0)};
        tbl[13] = '{r: 0, st: 0, cv: 1, c: 8'd1,   ak: 0, e: o(0, 0, 0, 0, 0, 1)};

        for (int i = 0; i < 16; i++) begin
            va[i] = 8'd0;
            vz[i] = 8'd0;
            vc[i] = 8'd1;
        end
        va[0] = 8'd3; va[1] = 8'd7; va[2] = 8'd2; va[3] = 8'd9; va[4] = 8'd9; va[5] = 8'd1;
        vc[0] = 8'd5; vc[1] = 8'd5; vc[2] = 8'd8;

        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].st, tbl[i].cv, tbl[i].c, tbl[i].ak, 1, tbl[i].e,
                $sformatf("vec%0d", i));
        end

        // Strict max, then done held without ack, ignored start, err in DONE.
        cyc(0, 1, 0, 8'd0, 0, 1, o(0, 0, 0, 1, 0, 0), "start_a");
        feed(va, "strict_max");
        for (int k = 0; k < 10; k++) begin
            cyc(0, k == 3, k == 6, 8'd250, 0, 1, o(9, 3, 1, 0, 1, k >= 6), "done_hold");
        end
        cyc(0, 0, 0, 8'd0, 1, 1, o(9, 3, 1, 0, 0, 1), "ack_idle");
        cyc(0, 1, 0, 8'd0, 0, 1, o(0, 0, 0, 1, 0, 0), "start_clears_err");

        // All-zero search.
        feed(vz, "zero_search");
        cyc(0, 0, 0, 8'd0, 0, 1, o(0, 0, 1, 0, 1, 0), "zero_final");

        // ack+start together re-enter COLLECT directly.
        cyc(0, 1, 0, 8'd0, 1, 1, o(0, 0, 0, 1, 0, 0), "ack_start");
        feed(vc, "late_winner");
        cyc(0, 0, 0, 8'd0, 0, 1, o(8, 2, 0, 0, 1, 0), "late_final");
        cyc(0, 0, 0, 8'd0, 1, 1, o(8, 2, 0, 0, 0, 0), "late_ack");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
